// File: rtl/sample_bank_scheduler.sv
// Ping-pong scheduler for a two-bank sample RAM. The ADC capture path fills one
// bank while the FFT engine is streamed the other completed bank. This block
// drives every RAM control signal.
module sample_bank_scheduler #(
  parameter int unsigned FRAME_LOG2 = 14,
  parameter int unsigned DATA_W     = 12
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [DATA_W-1:0]     adc_measurements,
  input  logic                  is_receiving_measurements,
  input  logic                  button_pressed,
  input  logic                  fft_ready,
  input  logic                  fft_done,
  output logic                  ram_wr_en,
  output logic                  ram_wr_bank,
  output logic [FRAME_LOG2-1:0] ram_wr_address,
  output logic [DATA_W-1:0]     ram_wr_data,
  output logic                  ram_rd_en,
  output logic                  ram_rd_bank,
  output logic [FRAME_LOG2-1:0] ram_rd_address,
  output logic                  frame_valid,
  output logic                  frame_first,
  output logic                  frame_last,
  output logic                  recording,
  output logic                  overrun
);

  localparam logic [FRAME_LOG2-1:0] LastAddr = {FRAME_LOG2{1'b1}};

  typedef enum logic {
    CIdle,
    CCapture
  } cap_state_e;

  typedef enum logic [1:0] {
    RIdle,
    RWait,
    RStream,
    RBusy
  } rd_state_e;

  cap_state_e            r_cap_state;
  rd_state_e             r_rd_state;
  logic [1:0]            r_full;
  logic                  r_oldest;     // bank filled first when both are full
  logic                  r_wr_bank;
  logic [FRAME_LOG2-1:0] r_wr_count;
  logic                  r_rd_bank;
  logic [FRAME_LOG2-1:0] r_rd_addr;
  logic                  r_rd_en;
  logic                  r_wr_en;
  logic                  r_wr_out_bank;
  logic [FRAME_LOG2-1:0] r_wr_addr;
  logic [DATA_W-1:0]     r_wr_data;
  logic                  r_recording;
  logic                  r_overrun;
  logic                  r_frame_valid;
  logic                  r_frame_first;
  logic                  r_frame_last;

  logic [1:0]            w_free;
  logic                  w_strobe;
  logic                  w_wr_accept;
  logic                  w_wr_last;
  logic                  w_rd_release;

  // Bank availability and the write/release events that update the full flags.
  always_comb begin
    w_free       = 2'b00;
    w_free[0]    = !r_full[0] && !((r_rd_state != RIdle) && (r_rd_bank == 1'b0));
    w_free[1]    = !r_full[1] && !((r_rd_state != RIdle) && (r_rd_bank == 1'b1));
    // A press in the same cycle always wins over the strobe.
    w_strobe     = (r_cap_state == CCapture) && is_receiving_measurements && !button_pressed;
    w_wr_accept  = w_strobe && w_free[r_wr_bank];
    w_wr_last    = w_wr_accept && (r_wr_count == LastAddr);
    w_rd_release = (r_rd_state == RBusy) && fft_done;
  end

  // Full flags and fill order; set on the last accepted write, cleared on fft_done.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_full   <= 2'b00;
      r_oldest <= 1'b0;
    end else begin
      if (w_wr_last) begin
        r_full[r_wr_bank] <= 1'b1;
        // The other bank stays older only if it remains full after this cycle.
        r_oldest <= (r_full[!r_wr_bank] && !(w_rd_release && (r_rd_bank == !r_wr_bank)))
                    ? !r_wr_bank : r_wr_bank;
      end
      if (w_rd_release) begin
        r_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  // Capture FSM: start/stop on button, registered RAM write port, overrun flag.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_cap_state   <= CIdle;
      r_recording   <= 1'b0;
      r_overrun     <= 1'b0;
      r_wr_bank     <= 1'b0;
      r_wr_count    <= '0;
      r_wr_en       <= 1'b0;
      r_wr_out_bank <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_cap_state)
        CIdle: begin
          if (button_pressed) begin
            r_cap_state <= CCapture;
            r_recording <= 1'b1;
            r_overrun   <= 1'b0;
            r_wr_count  <= '0;
            r_wr_bank   <= w_free[0] ? 1'b0 : 1'b1;
          end
        end
        CCapture: begin
          if (button_pressed) begin
            // Partial frame is abandoned; its bank never becomes full.
            r_cap_state <= CIdle;
            r_recording <= 1'b0;
            r_wr_count  <= '0;
          end else if (is_receiving_measurements) begin
            if (w_free[r_wr_bank]) begin
              r_wr_en       <= 1'b1;
              r_wr_out_bank <= r_wr_bank;
              r_wr_addr     <= r_wr_count;
              r_wr_data     <= adc_measurements;
              r_wr_count    <= r_wr_count + 1'b1;
              if (r_wr_count == LastAddr) begin
                r_wr_bank <= !r_wr_bank;
              end
            end else begin
              r_overrun <= 1'b1;
            end
          end
        end
        default: r_cap_state <= CIdle;
      endcase
    end
  end

  // Read FSM: pick the older full bank, wait for the FFT, stream, wait for done.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_rd_state    <= RIdle;
      r_rd_bank     <= 1'b0;
      r_rd_addr     <= '0;
      r_rd_en       <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_first <= 1'b0;
      r_frame_last  <= 1'b0;
    end else begin
      // Frame strobes track the RAM's one-cycle read latency.
      r_frame_valid <= r_rd_en;
      r_frame_first <= r_rd_en && (r_rd_addr == '0);
      r_frame_last  <= r_rd_en && (r_rd_addr == LastAddr);
      case (r_rd_state)
        RIdle: begin
          if (|r_full) begin
            r_rd_state <= RWait;
            r_rd_bank  <= (&r_full) ? r_oldest : r_full[1];
          end
        end
        RWait: begin
          if (fft_ready) begin
            r_rd_state <= RStream;
            r_rd_en    <= 1'b1;
            r_rd_addr  <= '0;
          end
        end
        RStream: begin
          if (r_rd_addr == LastAddr) begin
            r_rd_en    <= 1'b0;
            r_rd_state <= RBusy;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        RBusy: begin
          if (fft_done) begin
            r_rd_state <= RIdle;
          end
        end
        default: r_rd_state <= RIdle;
      endcase
    end
  end

  assign ram_wr_en      = r_wr_en;
  assign ram_wr_bank    = r_wr_out_bank;
  assign ram_wr_address = r_wr_addr;
  assign ram_wr_data    = r_wr_data;
  assign ram_rd_en      = r_rd_en;
  assign ram_rd_bank    = r_rd_bank;
  assign ram_rd_address = r_rd_addr;
  assign frame_valid    = r_frame_valid;
  assign frame_first    = r_frame_first;
  assign frame_last     = r_frame_last;
  assign recording      = r_recording;
  assign overrun        = r_overrun;

endmodule

// File: doc/sample_bank_scheduler.md
# sample_bank_scheduler

Ping-pong scheduler that shares a two-bank sample RAM between the ADC capture path and the FFT engine. While recording, ADC samples fill one bank. The FFT is handed the other, completed bank as a streamed frame, then released. It sits between the ADC front end, the dual-bank sample RAM and the FFT core, and owns every RAM control signal.

## Interface
- FRAME_LOG2, 14: log2 of samples per frame; a frame is 2^FRAME_LOG2 samples.
- DATA_W, 12: ADC sample width.
- CLOCK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- adc_measurements  in  DATA_W  ADC sample, qualified by is_receiving_measurements.
- is_receiving_measurements  in  1  single-cycle strobe; one valid sample per high cycle.
- button_pressed  in  1  single-cycle, debounced pulse; toggles recording on/off.
- fft_ready  in  1  FFT can accept a new frame.
- fft_done  in  1  single-cycle pulse; FFT has finished the frame it was given.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_bank  out  1  bank being written.
- ram_wr_address  out  FRAME_LOG2  write address within the bank.
- ram_wr_data  out  DATA_W  write data.
- ram_rd_en  out  1  RAM read enable; RAM read latency is 1 cycle.
- ram_rd_bank  out  1  bank being read.
- ram_rd_address  out  FRAME_LOG2  read address.
- frame_valid  out  1  RAM q is a valid frame sample this cycle.
- frame_first  out  1  with frame_valid, marks sample 0.
- frame_last  out  1  with frame_valid, marks sample 2^FRAME_LOG2-1.
- recording  out  1  capture active.
- overrun  out  1  sticky; a sample was dropped because no bank was free.

## Operation
- Bank state: full[1:0] flags, plus wr_bank and rd_bank pointers. A bank is free when it is not full and not being read.
- Capture FSM states: C_IDLE and C_CAPTURE.
  - C_IDLE -> C_CAPTURE on button_pressed. wr_count is cleared, and wr_bank is set to bank 0 if free, otherwise bank 1.
  - C_CAPTURE -> C_IDLE on button_pressed. The partial frame is discarded: its bank is not marked full and wr_count is cleared.
- Write rules in C_CAPTURE:
  - Each strobe while the current wr_bank is free writes adc_measurements at wr_count, then increments wr_count.
  - On the write of the last sample (wr_count == 2^FRAME_LOG2-1): set full[wr_bank], wrap wr_count to 0, and switch wr_bank to the other bank.
  - If the target bank is not free, the strobe is dropped, overrun is set, and wr_count holds.
  - Capture resumes automatically once the bank frees.
- Read FSM states: R_IDLE, R_WAIT, R_STREAM, R_BUSY.
  - R_IDLE -> R_WAIT when any full bit is set. rd_bank selects the older full bank. Order alternates, so it is always the bank filled first.
  - R_WAIT -> R_STREAM when fft_ready is high.
  - R_STREAM issues ram_rd_en for 2^FRAME_LOG2 consecutive cycles, addresses 0..2^FRAME_LOG2-1 with no gaps, then -> R_BUSY.
  - R_BUSY -> R_IDLE on fft_done. This clears full[rd_bank], freeing it.
- Simultaneous events:
  - Button press and strobe in the same cycle: the press wins and that sample is not written, whether starting or stopping.
  - fft_done in the same cycle a strobe targets the freed bank: the strobe is dropped. Freeing takes effect the next cycle.
  - fft_done outside R_BUSY is ignored.
- Stopping recording does not affect the read FSM; full banks are still delivered.
- overrun clears only on RESET or on a button press that starts recording.

## Timing
- Reset values: all outputs 0; both FSMs idle; full = 00; wr_bank = rd_bank = 0; counters 0. Reset mid-stream aborts with no further frame_valid.
- Write: RAM outputs are registered. ram_wr_en/address/data are asserted the cycle after the accepting strobe, for exactly one cycle.
- full is set in the cycle ram_wr_en writes the last address, and is visible to the read FSM the following cycle.
- Read: frame_valid, frame_first and frame_last are ram_rd_en, first and last delayed by 1 cycle. frame_valid is high for exactly 2^FRAME_LOG2 consecutive cycles per frame.
- Latency: from the R_WAIT cycle with fft_ready high to the first ram_rd_en is 1 cycle, and to frame_first is 2 cycles.
- recording is high the cycle after the start press and low the cycle after the stop press.

## Test plan
- Use FRAME_LOG2=4 for all scenarios.
- Basic frame: press, 16 strobes with data 0..15, fft_ready=1 -> 16 writes to bank 0 at addresses 0..15. Then frame_valid for 16 cycles, with frame_first on data 0 and frame_last on data 15.
- Ping-pong: 32 strobes with the FFT held busy -> bank 0 then bank 1 fill, and no overrun. After fft_done, bank 1 streams next.
- Overrun: both banks full, 3 more strobes -> no ram_wr_en, overrun=1, wr_count=0. After fft_done the next strobe writes the freed bank at address 0.
- Mid-frame stop: press, 5 strobes, press -> recording=0 and no frame_valid ever. Restart refills bank 0 from address 0.
- Simultaneous press+strobe at start, then at stop -> neither sample is written. ram_wr_address sequence shows no entries for those samples.
- RESET asserted during R_STREAM at sample 7 -> the next cycle has all outputs 0, and full=00.
